// File: rtl/fx_pkg.sv
// Shared fx bus definitions: address split, register offsets and the decoded address view.
package fx_pkg;

    localparam int unsigned FX_AW = 22;
    localparam int unsigned FX_WW = 14;
    localparam int unsigned FX_OW = 8;
    localparam int unsigned FX_DW = 8;
    localparam int unsigned FX_TSW = 32;

    localparam logic [FX_OW-1:0] FX_OFS_ID   = 8'h00;
    localparam logic [FX_OW-1:0] FX_OFS_CTRL = 8'h01;
    localparam logic [FX_OW-1:0] FX_OFS_CMD  = 8'h02;
    localparam logic [FX_OW-1:0] FX_OFS_STAT = 8'h03;
    localparam logic [FX_OW-1:0] FX_OFS_TS0  = 8'h04;
    localparam logic [FX_OW-1:0] FX_OFS_TS1  = 8'h05;
    localparam logic [FX_OW-1:0] FX_OFS_TS2  = 8'h06;
    localparam logic [FX_OW-1:0] FX_OFS_TS3  = 8'h07;
    localparam logic [FX_OW-1:0] FX_OFS_CFG0 = 8'h08;
    localparam logic [FX_OW-1:0] FX_OFS_CFG1 = 8'h09;
    localparam logic [FX_OW-1:0] FX_OFS_CFG2 = 8'h0A;
    localparam logic [FX_OW-1:0] FX_OFS_CFG3 = 8'h0B;

    // Bus address seen as window select plus in-window offset.
    typedef struct packed {
        logic [FX_WW-1:0] win;
        logic [FX_OW-1:0] ofs;
    } fx_addr_t;

endpackage

// File: rtl/fx_ts_snap.sv
// Free-running timestamp with a snapshot register so multi-byte reads are coherent.
module fx_ts_snap
    import fx_pkg::*;
(
    input  logic             clk_sys,
    input  logic             rst_n,
    input  logic             snap_en,
    input  logic [1:0]       ofs,
    output logic [FX_DW-1:0] rd_byte_c
);

    logic [FX_TSW-1:0] ts;
    logic [FX_TSW-1:0] snap;

    // Byte 0 comes live from ts; snap captures the same value so bytes 1..3 match it.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            ts   <= '0;
            snap <= '0;
        end else begin
            ts <= ts + 32'd1;
            if (snap_en) begin
                snap <= ts;
            end
        end
    end

    always_comb begin
        rd_byte_c = ts[7:0];
        case (ofs)
            2'd1:    rd_byte_c = snap[15:8];
            2'd2:    rd_byte_c = snap[23:16];
            2'd3:    rd_byte_c = snap[31:24];
            default: rd_byte_c = ts[7:0];
        endcase
    end

endmodule

// File: rtl/fx_reg_slave.sv
// fx bus register slave: address decode, control/command/status/config registers and read return.
module fx_reg_slave
    import fx_pkg::*;
#(
    parameter logic [FX_WW-1:0] BASE = 14'h0040,
    parameter logic [FX_DW-1:0] ID   = 8'h5A
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              fx_wr,
    input  logic [FX_AW-1:0]  fx_waddr,
    input  logic [FX_DW-1:0]  fx_data,
    input  logic              fx_rd,
    input  logic [FX_AW-1:0]  fx_raddr,
    output logic [FX_DW-1:0]  fx_q,
    output logic [FX_DW-1:0]  cfg_ctrl,
    output logic [FX_TSW-1:0] cfg_word,
    output logic [FX_DW-1:0]  cmd_pulse,
    input  logic [FX_DW-1:0]  stat_evt
);

    fx_addr_t         waddr;
    fx_addr_t         raddr;
    logic             wr_hit_c;
    logic             rd_hit_c;
    logic             snap_en_c;
    logic [FX_DW-1:0] w1c_c;
    logic [FX_DW-1:0] ts_byte_c;
    logic [FX_DW-1:0] rd_val_c;
    logic [FX_DW-1:0] stat;

    assign waddr     = fx_waddr;
    assign raddr     = fx_raddr;
    assign wr_hit_c  = fx_wr && (waddr.win == BASE);
    assign rd_hit_c  = fx_rd && (raddr.win == BASE);
    assign snap_en_c = rd_hit_c && (raddr.ofs == FX_OFS_TS0);
    assign w1c_c     = (wr_hit_c && (waddr.ofs == FX_OFS_STAT)) ? fx_data : '0;

    fx_ts_snap u_ts (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .snap_en   (snap_en_c),
        .ofs       (raddr.ofs[1:0]),
        .rd_byte_c (ts_byte_c)
    );

    // Read mux: misses and unmapped offsets return 0 so the OR fabric stays clean.
    always_comb begin
        rd_val_c = '0;
        if (rd_hit_c) begin
            case (raddr.ofs)
                FX_OFS_ID:   rd_val_c = ID;
                FX_OFS_CTRL: rd_val_c = cfg_ctrl;
                FX_OFS_STAT: rd_val_c = stat;
                FX_OFS_TS0,
                FX_OFS_TS1,
                FX_OFS_TS2,
                FX_OFS_TS3:  rd_val_c = ts_byte_c;
                FX_OFS_CFG0: rd_val_c = cfg_word[7:0];
                FX_OFS_CFG1: rd_val_c = cfg_word[15:8];
                FX_OFS_CFG2: rd_val_c = cfg_word[23:16];
                FX_OFS_CFG3: rd_val_c = cfg_word[31:24];
                default:     rd_val_c = '0;
            endcase
        end
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            fx_q      <= '0;
            cfg_ctrl  <= '0;
            cfg_word  <= '0;
            cmd_pulse <= '0;
            stat      <= '0;
        end else begin
            cmd_pulse <= '0;
            // Event set is applied after the clear so a same-cycle event wins.
            stat      <= (stat & ~w1c_c) | stat_evt;
            if (fx_rd) begin
                fx_q <= rd_val_c;
            end
            if (wr_hit_c) begin
                case (waddr.ofs)
                    FX_OFS_CTRL: cfg_ctrl        <= fx_data;
                    FX_OFS_CMD:  cmd_pulse       <= fx_data;
                    FX_OFS_CFG0: cfg_word[7:0]   <= fx_data;
                    FX_OFS_CFG1: cfg_word[15:8]  <= fx_data;
                    FX_OFS_CFG2: cfg_word[23:16] <= fx_data;
                    FX_OFS_CFG3: cfg_word[31:24] <= fx_data;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_fx_reg_slave.sv
// Self-checking bench for fx_reg_slave: scoreboard of expected read returns plus direct output checks.
module tb_fx_reg_slave;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic        fx_wr;
    logic [21:0] fx_waddr;
    logic [7:0]  fx_data;
    logic        fx_rd;
    logic [21:0] fx_raddr;
    logic [7:0]  fx_q;
    logic [7:0]  cfg_ctrl;
    logic [31:0] cfg_word;
    logic [7:0]  cmd_pulse;
    logic [7:0]  stat_evt;

    int total = 0;
    int bad   = 0;
    logic [7:0]  sb[$];
    logic [7:0]  exp_q;
    logic [31:0] ts_m;
    logic [31:0] snap_m = 32'h0;

    localparam logic [13:0] WIN  = 14'h0040;
    localparam logic [13:0] MISS = 14'h0041;

    always #5 clk_sys = ~clk_sys;

    fx_reg_slave dut (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .fx_wr     (fx_wr),
        .fx_waddr  (fx_waddr),
        .fx_data   (fx_data),
        .fx_rd     (fx_rd),
        .fx_raddr  (fx_raddr),
        .fx_q      (fx_q),
        .cfg_ctrl  (cfg_ctrl),
        .cfg_word  (cfg_word),
        .cmd_pulse (cmd_pulse),
        .stat_evt  (stat_evt)
    );

    // Reference timestamp: 0 while in reset, counts every edge afterwards.
    always @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) ts_m <= 32'h0;
        else        ts_m <= ts_m + 32'h1;
    end

    function automatic logic [21:0] a(input logic [7:0] o);
        return {WIN, o};
    endfunction

    // One bus cycle: drive at negedge, push the expected read return, return just after the edge.
    task automatic step(input logic wr, input logic [21:0] wa, input logic [7:0] wd,
                        input logic rd, input logic [21:0] ra, input logic [7:0] exp, input logic use_ts);
        logic [7:0] e;
        logic [7:0] o;
        @(negedge clk_sys);
        fx_wr = wr; fx_waddr = wa; fx_data = wd;
        fx_rd = rd; fx_raddr = ra;
        if (rd) begin
            e = exp;
            o = ra[7:0];
            if (use_ts) begin
                case (o)
                    8'h04:   begin e = ts_m[7:0]; snap_m = ts_m; end
                    8'h05:   e = snap_m[15:8];
                    8'h06:   e = snap_m[23:16];
                    8'h07:   e = snap_m[31:24];
                    default: e = exp;
                endcase
            end
            sb.push_back(e);
        end
        @(posedge clk_sys);
        #1;
    endtask

    task automatic rd(input logic [21:0] ra, input logic [7:0] exp);
        step(1'b0, 22'h0, 8'h0, 1'b1, ra, exp, 1'b0);
    endtask

    task automatic wr(input logic [21:0] wa, input logic [7:0] wd);
        step(1'b1, wa, wd, 1'b0, 22'h0, 8'h0, 1'b0);
    endtask

    task automatic idle();
        step(1'b0, 22'h0, 8'h0, 1'b0, 22'h0, 8'h0, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; fx_wr = 1'b0; fx_rd = 1'b0; fx_waddr = '0; fx_raddr = '0;
        fx_data = '0; stat_evt = '0;
        repeat (3) @(posedge clk_sys);
        @(negedge clk_sys);
        total++;
        if ({fx_q, cfg_ctrl, cfg_word, cmd_pulse} !== 56'h0) begin
            bad++;
            $display("FAIL reset_outputs: got q=%h ctrl=%h word=%h cmd=%h, want all 0",
                     fx_q, cfg_ctrl, cfg_word, cmd_pulse);
        end
        // Release and read TS0 in the same cycle: the first timestamp seen is 0.
        rst_n = 1'b1; fx_rd = 1'b1; fx_raddr = a(8'h04);
        sb.push_back(8'h00);
        @(posedge clk_sys); #1;
        exp_q = sb.pop_front(); total++;
        if (fx_q !== exp_q) begin bad++; $display("FAIL ts_first: got %h want %h", fx_q, exp_q); end
        rd(a(8'h00), 8'h5A);
        exp_q = sb.pop_front(); total++;
        if (fx_q !== exp_q) begin bad++; $display("FAIL id_read: got %h want %h", fx_q, exp_q); end
        repeat (3) idle();
        for (int i = 4; i < 6; i++) begin
            step(1'b0, 22'h0, 8'h0, 1'b1, a(8'(i)), 8'h00, 1'b1);
            exp_q = sb.pop_front(); total++;
            if (fx_q !== exp_q) begin bad++; $display("FAIL ts_count ofs%0d: got %h want %h", i, fx_q, exp_q); end
        end
        idle();
    endtask

    task automatic test_miss();
        rd(a(8'h00), 8'h5A);
        exp_q = sb.pop_front(); total++;
        if (fx_q !== exp_q) begin bad++; $display("FAIL id_again: got %h want %h", fx_q, exp_q); end
        rd({MISS, 8'h00}, 8'h00);
        exp_q = sb.pop_front(); total++;
        if (fx_q !== exp_q) begin bad++; $display("FAIL miss_window: got %h want %h", fx_q, exp_q); end
        wr(a(8'h01), 8'hA5);
        total++;
        if (cfg_ctrl !== 8'hA5) begin bad++; $display("FAIL ctrl_out: got %h want a5", cfg_ctrl); end
        wr({MISS, 8'h01}, 8'h3C);
        wr(a(8'h00), 8'hFF);
        wr(a(8'h0C), 8'h77);
        total++;
        if (cfg_ctrl !== 8'hA5) begin bad++; $display("FAIL ctrl_miss_write: got %h want a5", cfg_ctrl); end
        rd(a(8'h01), 8'hA5);
        exp_q = sb.pop_front(); total++;
        if (fx_q !== exp_q) begin bad++; $display("FAIL ctrl_read: got %h want %h", fx_q, exp_q); end
        idle(); idle();
        total++;
        if (fx_q !== 8'hA5) begin bad++; $display("FAIL q_hold: got %h want a5", fx_q); end
        rd(a(8'h00), 8'h5A);
        exp_q = sb.pop_front(); total++;
        if (fx_q !== exp_q) begin bad++; $display("FAIL id_readonly: got %h want %h", fx_q, exp_q); end
        rd(a(8'h0C), 8'h00);
        exp_q = sb.pop_front(); total++;
        if (fx_q !== exp_q) begin bad++; $display("FAIL unmapped: got %h want %h", fx_q, exp_q); end
        idle();
    endtask

    task automatic test_cmd();
        wr(a(8'h02), 8'h81);
        total++;
        if (cmd_pulse !== 8'h81) begin bad++; $display("FAIL cmd_pulse_on: got %h want 81", cmd_pulse); end
        idle();
        total++;
        if (cmd_pulse !== 8'h00) begin bad++; $display("FAIL cmd_pulse_off: got %h want 00", cmd_pulse); end
        rd(a(8'h01), 8'hA5);
        exp_q = sb.pop_front(); total++;
        if (fx_q !== exp_q) begin bad++; $display("FAIL b2b_ctrl: got %h want %h", fx_q, exp_q); end
        rd(a(8'h02), 8'h00);
        exp_q = sb.pop_front(); total++;
        if (fx_q !== exp_q) begin bad++; $display("FAIL cmd_read: got %h want %h", fx_q, exp_q); end
        idle();
    endtask

    task automatic test_stat();
        stat_evt = 8'h05;
        idle();
        stat_evt = 8'h00;
        rd(a(8'h03), 8'h05);
        exp_q = sb.pop_front(); total++;
        if (fx_q !== exp_q) begin bad++; $display("FAIL stat_set: got %h want %h", fx_q, exp_q); end
        // W1C of bit 0 while event bit 0 fires; same-cycle read sees the old value.
        stat_evt = 8'h01;
        step(1'b1, a(8'h03), 8'h01, 1'b1, a(8'h03), 8'h05, 1'b0);
        stat_evt = 8'h00;
        exp_q = sb.pop_front(); total++;
        if (fx_q !== exp_q) begin bad++; $display("FAIL stat_collide_rd: got %h want %h", fx_q, exp_q); end
        rd(a(8'h03), 8'h05);
        exp_q = sb.pop_front(); total++;
        if (fx_q !== exp_q) begin bad++; $display("FAIL stat_set_wins: got %h want %h", fx_q, exp_q); end
        wr(a(8'h03), 8'h04);
        rd(a(8'h03), 8'h01);
        exp_q = sb.pop_front(); total++;
        if (fx_q !== exp_q) begin bad++; $display("FAIL stat_w1c: got %h want %h", fx_q, exp_q); end
        idle();
    endtask

    task automatic test_cfg();
        for (int i = 0; i < 4; i++) wr(a(8'(8 + i)), 8'(8'h11 * (i + 1)));
        total++;
        if (cfg_word !== 32'h4433_2211) begin bad++; $display("FAIL cfg_word: got %h want 44332211", cfg_word); end
        step(1'b1, a(8'h08), 8'h55, 1'b1, a(8'h08), 8'h11, 1'b0);
        exp_q = sb.pop_front(); total++;
        if (fx_q !== exp_q) begin bad++; $display("FAIL cfg_collide_rd: got %h want %h", fx_q, exp_q); end
        total++;
        if (cfg_word !== 32'h4433_2255) begin bad++; $display("FAIL cfg_collide_wr: got %h want 44332255", cfg_word); end
        for (int i = 0; i < 4; i++) begin
            rd(a(8'(8 + i)), (i == 0) ? 8'h55 : 8'(8'h11 * (i + 1)));
            exp_q = sb.pop_front(); total++;
            if (fx_q !== exp_q) begin bad++; $display("FAIL cfg_read%0d: got %h want %h", i, fx_q, exp_q); end
        end
        idle();
    endtask

    task automatic test_ts();
        logic [7:0] e_co[4];
        logic [7:0] o_co[4];
        logic [7:0] e_wr[4];
        logic [7:0] o_wr[4];
        o_co = '{8'h04, 8'h05, 8'h06, 8'h07};
        e_co = '{8'hFF, 8'hFF, 8'hFF, 8'h00};
        o_wr = '{8'h04, 8'h04, 8'h07, 8'h05};
        e_wr = '{8'hFF, 8'h00, 8'h00, 8'h00};
        force dut.u_ts.ts = 32'h00FF_FFFF;
        #1 release dut.u_ts.ts;
        for (int i = 0; i < 4; i++) begin
            rd(a(o_co[i]), e_co[i]);
            exp_q = sb.pop_front(); total++;
            if (fx_q !== exp_q) begin bad++; $display("FAIL ts_coherent%0d: got %h want %h", i, fx_q, exp_q); end
        end
        force dut.u_ts.ts = 32'hFFFF_FFFF;
        #1 release dut.u_ts.ts;
        for (int i = 0; i < 4; i++) begin
            rd(a(o_wr[i]), e_wr[i]);
            exp_q = sb.pop_front(); total++;
            if (fx_q !== exp_q) begin bad++; $display("FAIL ts_wrap%0d: got %h want %h", i, fx_q, exp_q); end
        end
        idle();
    endtask

    task automatic test_reset_mid();
        rd(a(8'h00), 8'h5A);
        exp_q = sb.pop_front(); total++;
        if (fx_q !== exp_q) begin bad++; $display("FAIL pre_reset_id: got %h want %h", fx_q, exp_q); end
        @(negedge clk_sys);
        fx_rd = 1'b1; fx_raddr = a(8'h01);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({fx_q, cfg_ctrl, cfg_word} !== 48'h0) begin
            bad++;
            $display("FAIL reset_mid: got q=%h ctrl=%h word=%h, want all 0", fx_q, cfg_ctrl, cfg_word);
        end
        @(negedge clk_sys);
        rst_n = 1'b1; fx_rd = 1'b0;
        rd(a(8'h03), 8'h00);
        exp_q = sb.pop_front(); total++;
        if (fx_q !== exp_q) begin bad++; $display("FAIL stat_after_reset: got %h want %h", fx_q, exp_q); end
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_miss();
        test_cmd();
        test_stat();
        test_cfg();
        test_ts();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
